// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types, defaults and flattened-bus helper for the register file
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DEF_DATA_W = 32;
  localparam int RF_DEF_ADDR_W = 5;

  // LSB position of field k in a bus of packed w-bit fields
  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with set/clear priority and NRD lookup ports
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_set,
  input  logic [ADDR_W-1:0]     i_set_addr,
  input  logic                  i_clr,
  input  logic [ADDR_W-1:0]     i_clr_addr,
  input  logic [NRD*ADDR_W-1:0] i_rd_addr,
  output logic [NRD-1:0]        o_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_en) begin
      if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
      // set applied last: a newly issued producer supersedes the retiring write
      if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
    end
    if (ZERO_REG) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_lookup
    assign o_busy[k] = r_busy[i_rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W]];
  end

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - parametrised multi-read register file with clear sweep, bypass and busy scoreboard
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DEF_DATA_W,
  parameter int ADDR_W   = RF_DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RFWE,
  input  logic [ADDR_W-1:0]     RFWA,
  input  logic [DATA_W-1:0]     RFWD,
  input  logic [NRD*ADDR_W-1:0] RFRA,
  output logic [NRD*DATA_W-1:0] RFRD,
  input  logic                  SBSET,
  input  logic [ADDR_W-1:0]     SBSA,
  output logic [NRD-1:0]        RFBUSY,
  output logic                  RFREADY
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_ready;
  logic              w_wr_en;
  logic [NRD-1:0]    w_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RF_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == RF_CLEAR) begin
      w_idx_nxt = r_idx + ADDR_W'(1);
      if (r_idx == LAST_IDX) w_state_nxt = RF_READY;
    end
  end

  assign w_ready = (r_state == RF_READY);
  assign w_wr_en = w_ready && RFWE && !(ZERO_REG && (RFWA == '0));

  // Single write port with no reset on the array, so it can map onto RAM
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (!w_ready)     r_mem[r_idx] <= '0;
      else if (w_wr_en) r_mem[RFWA]  <= RFWD;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = RFRA[slice_lsb(k, ADDR_W) +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
      if (BYPASS && RFWE && (RFWA == w_addr)) w_data = RFWD;
      if (!w_ready || (ZERO_REG && (w_addr == '0))) w_data = '0;
    end

    assign RFRD[slice_lsb(k, DATA_W) +: DATA_W] = w_data;
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NRD     (NRD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_en      (w_ready),
    .i_set     (SBSET),
    .i_set_addr(SBSA),
    .i_clr     (RFWE),
    .i_clr_addr(RFWA),
    .i_rd_addr (RFRA),
    .o_busy    (w_busy)
  );

  assign RFBUSY  = w_busy & {NRD{w_ready}};
  assign RFREADY = w_ready;

endmodule
